// File: rtl/mcpu_mem_il1c_nway.sv
`default_nettype none
// ============================================================================
// Module   : mcpu_mem_il1c_nway
// Purpose  : N-way set-associative instruction L1 cache, virtually indexed,
//            physically tagged, 32-byte lines, 128-bit packets to fetch.
//            Per-set round-robin replacement, whole-cache flush, arbiter
//            stall handling.
// Ports    : clkrst_mem_clk/rst    clock, synchronous active-high reset
//            il1c_*                fetch packet interface (addr = [31:4])
//            il1c2tlb_*            virtual page lookup, physical page return
//            il1c2arb_*            line read request and 256-bit fill return
// Revision : 1.0 - initial release
// ============================================================================
module mcpu_mem_il1c_nway #(
  parameter int SET_WIDTH = 4,
  parameter int WAY_BITS  = 1
) (
  input  logic           clkrst_mem_clk,
  input  logic           clkrst_mem_rst,
  input  logic [27:0]    il1c_addr,
  input  logic           il1c_re,
  output logic           il1c_ready,
  output logic [127:0]   il1c_packet,
  output logic           il1c_packet_valid,
  input  logic           il1c_flush,
  output logic [19:0]    il1c2tlb_addr,
  output logic           il1c2tlb_re,
  input  logic [19:0]    il1c2tlb_phys_addr,
  input  logic           il1c2tlb_ready,
  output logic           il1c2arb_valid,
  output logic [2:0]     il1c2arb_opcode,
  output logic [26:0]    il1c2arb_addr,
  input  logic           il1c2arb_stall,
  input  logic [255:0]   il1c2arb_rdata,
  input  logic           il1c2arb_rvalid
);

  localparam int TAG_WIDTH = 27 - SET_WIDTH;
  localparam int NUM_WAYS  = 1 << WAY_BITS;
  localparam int NUM_SETS  = 1 << SET_WIDTH;
  localparam int PTR_W     = (WAY_BITS > 0) ? WAY_BITS : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t state, state_nxt;

  // Storage
  logic [TAG_WIDTH-1:0] tag_ram  [NUM_WAYS][NUM_SETS];
  logic [255:0]         data_ram [NUM_WAYS][NUM_SETS];
  logic [NUM_SETS-1:0]  valid_q  [NUM_WAYS];
  logic [PTR_W-1:0]     rr_ptr   [NUM_SETS];

  // Registered RAM read ports
  logic [TAG_WIDTH-1:0] rd_tag  [NUM_WAYS];
  logic [255:0]         rd_data [NUM_WAYS];

  // _1a stage
  logic [27:0]          addr_1a;
  logic                 re_1a;
  logic [19:0]          phys_1a;
  logic                 flush_pend;
  logic [255:0]         fill_buf;

  logic                 accept;
  logic [SET_WIDTH-1:0] set_0a, set_1a, ram_set;
  logic [26:0]          line_lookup, line_fill;
  logic [TAG_WIDTH-1:0] tag_lookup, tag_fill;
  logic                 hit;
  logic [PTR_W-1:0]     hit_way, victim;
  logic                 victim_valid;
  logic                 fill_we;
  logic [255:0]         hit_line;

  assign accept  = il1c_re & il1c_ready;
  assign set_0a  = il1c_addr[SET_WIDTH:1];
  assign set_1a  = addr_1a[SET_WIDTH:1];
  // Keep the RAM address on the pending request unless a new one is taken.
  assign ram_set = accept ? set_0a : set_1a;

  // Tag is the line address above the index bits.
  assign line_lookup = {il1c2tlb_phys_addr, addr_1a[7:1]};
  assign line_fill   = {phys_1a, addr_1a[7:1]};
  assign tag_lookup  = TAG_WIDTH'(line_lookup >> SET_WIDTH);
  assign tag_fill    = TAG_WIDTH'(line_fill >> SET_WIDTH);

  assign il1c2tlb_addr   = accept ? il1c_addr[27:8] : addr_1a[27:8];
  // Lookup on accept, and keep retrying while the TLB has no answer.
  assign il1c2tlb_re     = accept | ((state == S_IDLE) & re_1a & ~il1c2tlb_ready);
  assign il1c2arb_opcode = 3'd0;
  assign il1c2arb_addr   = line_fill;
  assign fill_we         = (state == S_WAIT) & il1c2arb_rvalid;

  // Hit detection; scanning downward makes the lowest matching way win.
  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (valid_q[w][set_1a] && (rd_tag[w] == tag_lookup)) begin
        hit     = 1'b1;
        hit_way = PTR_W'(w);
      end
    end
  end

  assign hit_line = rd_data[hit_way];

  // Victim: lowest invalid way, else the set's round-robin pointer.
  always_comb begin
    victim       = rr_ptr[set_1a];
    victim_valid = 1'b1;
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (!valid_q[w][set_1a]) begin
        victim       = PTR_W'(w);
        victim_valid = 1'b0;
      end
    end
  end

  // Next state and outputs
  always_comb begin
    state_nxt         = state;
    il1c_ready        = 1'b0;
    il1c_packet_valid = 1'b0;
    il1c_packet       = addr_1a[0] ? fill_buf[255:128] : fill_buf[127:0];
    il1c2arb_valid    = 1'b0;
    case (state)
      S_IDLE: begin
        if (!re_1a) begin
          il1c_ready = 1'b1;
        end else if (il1c2tlb_ready) begin
          if (hit) begin
            il1c_ready        = 1'b1;
            il1c_packet_valid = 1'b1;
            il1c_packet       = addr_1a[0] ? hit_line[255:128] : hit_line[127:0];
          end else begin
            state_nxt = S_REQ;
          end
        end
      end
      S_REQ: begin
        il1c2arb_valid = 1'b1;
        if (!il1c2arb_stall) state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (il1c2arb_rvalid) state_nxt = S_DONE;
      end
      S_DONE: begin
        il1c_ready        = 1'b1;
        il1c_packet_valid = 1'b1;
        state_nxt         = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Control state with reset
  always_ff @(posedge clkrst_mem_clk) begin
    if (clkrst_mem_rst) begin
      state      <= S_IDLE;
      re_1a      <= 1'b0;
      flush_pend <= 1'b0;
      for (int w = 0; w < NUM_WAYS; w++) valid_q[w] <= '0;
      for (int s = 0; s < NUM_SETS; s++) rr_ptr[s] <= '0;
    end else begin
      state <= state_nxt;
      if (il1c_ready) re_1a <= il1c_re;

      // A flush while the line is in flight must not validate that line.
      if (state == S_DONE)
        flush_pend <= 1'b0;
      else if (il1c_flush && ((state == S_REQ) || (state == S_WAIT)))
        flush_pend <= 1'b1;

      if (il1c_flush) begin
        for (int w = 0; w < NUM_WAYS; w++) valid_q[w] <= '0;
      end else if (fill_we && !flush_pend) begin
        valid_q[victim][set_1a] <= 1'b1;
      end

      if (fill_we && victim_valid)
        rr_ptr[set_1a] <= (rr_ptr[set_1a] == PTR_W'(NUM_WAYS - 1)) ? '0
                                                                    : rr_ptr[set_1a] + 1'b1;
    end
  end

  // Datapath registers and RAMs (no reset needed)
  always_ff @(posedge clkrst_mem_clk) begin
    if (accept) addr_1a <= il1c_addr;
    if ((state == S_IDLE) && re_1a && il1c2tlb_ready) phys_1a <= il1c2tlb_phys_addr;
    if (fill_we) fill_buf <= il1c2arb_rdata;
    for (int w = 0; w < NUM_WAYS; w++) begin
      rd_tag[w]  <= tag_ram[w][ram_set];
      rd_data[w] <= data_ram[w][ram_set];
      if (fill_we && (victim == PTR_W'(w))) begin
        tag_ram[w][set_1a]  <= tag_fill;
        data_ram[w][set_1a] <= il1c2arb_rdata;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mcpu_mem_il1c_nway.sv
`default_nettype none
// ============================================================================
// Module   : tb_mcpu_mem_il1c_nway
// Purpose  : Directed self-checking bench for mcpu_mem_il1c_nway with TLB and
//            arbiter models and a packet scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mcpu_mem_il1c_nway;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [27:0]  il1c_addr = '0;
  logic         il1c_re = 1'b0;
  logic         il1c_ready;
  logic [127:0] il1c_packet;
  logic         il1c_packet_valid;
  logic         il1c_flush = 1'b0;
  logic [19:0]  il1c2tlb_addr;
  logic         il1c2tlb_re;
  logic [19:0]  il1c2tlb_phys_addr;
  logic         il1c2tlb_ready;
  logic         il1c2arb_valid;
  logic [2:0]   il1c2arb_opcode;
  logic [26:0]  il1c2arb_addr;
  logic         il1c2arb_stall = 1'b0;
  logic [255:0] il1c2arb_rdata;
  logic         il1c2arb_rvalid;

  always #5 clk = ~clk;

  mcpu_mem_il1c_nway #(.SET_WIDTH(4), .WAY_BITS(1)) dut (
    .clkrst_mem_clk     (clk),
    .clkrst_mem_rst     (rst),
    .il1c_addr          (il1c_addr),
    .il1c_re            (il1c_re),
    .il1c_ready         (il1c_ready),
    .il1c_packet        (il1c_packet),
    .il1c_packet_valid  (il1c_packet_valid),
    .il1c_flush         (il1c_flush),
    .il1c2tlb_addr      (il1c2tlb_addr),
    .il1c2tlb_re        (il1c2tlb_re),
    .il1c2tlb_phys_addr (il1c2tlb_phys_addr),
    .il1c2tlb_ready     (il1c2tlb_ready),
    .il1c2arb_valid     (il1c2arb_valid),
    .il1c2arb_opcode    (il1c2arb_opcode),
    .il1c2arb_addr      (il1c2arb_addr),
    .il1c2arb_stall     (il1c2arb_stall),
    .il1c2arb_rdata     (il1c2arb_rdata),
    .il1c2arb_rvalid    (il1c2arb_rvalid)
  );

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  task automatic check_v(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_i(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic timeout_fail(input string tag);
    tests++;
    fails++;
    $error("FAIL %s observed=timeout expected=event", tag);
  endtask

  // Reference memory and address translation
  function automatic logic [255:0] line_data(input logic [26:0] line);
    logic [255:0] d;
    for (int i = 0; i < 8; i++) d[32*i +: 32] = {5'(i), line};
    return d;
  endfunction

  function automatic logic [26:0] line_of(input logic [31:0] a);
    return {a[31:12] ^ 20'h00081, a[11:5]};
  endfunction

  function automatic logic [127:0] exp_pkt(input logic [31:0] a);
    logic [255:0] d;
    d = line_data(line_of(a));
    return a[4] ? d[255:128] : d[127:0];
  endfunction

  // TLB model: one-cycle lookup, result held until the next lookup
  logic [19:0] tlb_q = '0;
  logic        tlb_block = 1'b0;
  always @(posedge clk) if (il1c2tlb_re) tlb_q <= il1c2tlb_addr ^ 20'h00081;
  assign il1c2tlb_ready     = ~tlb_block;
  assign il1c2tlb_phys_addr = tlb_q;

  // Arbiter model: returns the line arb_lat cycles after the handshake
  int          arb_lat = 3;
  int          arb_pend = 0;
  int          arb_reqs = 0;
  logic [26:0] arb_line_q = '0;
  logic [2:0]  arb_op_q = 3'h7;
  always @(posedge clk) begin
    if (il1c2arb_valid && !il1c2arb_stall) begin
      arb_pend   <= arb_lat;
      arb_line_q <= il1c2arb_addr;
      arb_op_q   <= il1c2arb_opcode;
      arb_reqs   <= arb_reqs + 1;
    end else if (arb_pend > 0) begin
      arb_pend <= arb_pend - 1;
    end
  end
  assign il1c2arb_rvalid = (arb_pend == 1);
  assign il1c2arb_rdata  = line_data(arb_line_q);

  // Scoreboard
  logic [127:0] exp_q[$];
  int           pkt_cyc[$];
  int           acc_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (il1c_packet_valid) begin
      pkt_cyc.push_back(cyc);
      tests++;
      assert (exp_q.size() > 0) else begin
        fails++;
        $error("FAIL unexpected_packet observed=%h expected=none", il1c_packet);
      end
      if (exp_q.size() > 0) check_v("packet", 256'(il1c_packet), 256'(exp_q.pop_front()));
    end
  end

  task automatic issue(input logic [31:0] a);
    int  n = 0;
    bit  done = 0;
    @(posedge clk); #1;
    il1c_re   = 1'b1;
    il1c_addr = a[31:4];
    while (!done) begin
      @(negedge clk);
      if (il1c_ready) begin
        done    = 1;
        acc_cyc = cyc;
        exp_q.push_back(exp_pkt(a));
      end else if (++n > 200) begin
        timeout_fail("accept");
        done = 1;
      end
    end
    @(posedge clk); #1;
    il1c_re = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() > 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() > 0) begin
      timeout_fail("packet_wait");
      exp_q.delete();
    end
  endtask

  task automatic read(input logic [31:0] a, input int lat, output int pkt_lat, output int reqs);
    int r0;
    arb_lat = lat;
    r0 = arb_reqs;
    issue(a);
    drain();
    pkt_lat = (pkt_cyc.size() > 0) ? pkt_cyc[$] - acc_cyc : -1;
    reqs = arb_reqs - r0;
  endtask

  task automatic wait_arb_req(input int r0);
    int n = 0;
    while (arb_reqs == r0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (arb_reqs == r0) timeout_fail("arb_request");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  localparam logic [31:0] A = 32'h0000_2060;
  localparam logic [31:0] B = 32'h0000_3060;
  localparam logic [31:0] C = 32'h0000_4060;

  initial begin
    int lat, reqs, r0, p0, n, vcnt, rlow;
    logic [31:0] saddr [8];

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_i("reset_ready", int'(il1c_ready), 1);
    check_i("reset_pkt_valid", int'(il1c_packet_valid), 0);
    check_i("reset_arb_valid", int'(il1c2arb_valid), 0);
    check_i("reset_tlb_re", int'(il1c2tlb_re), 0);

    // Cold miss, then hit on the other half of the same line
    read(32'h0000_1000, 3, lat, reqs);
    check_i("cold_miss_reqs", reqs, 1);
    check_i("cold_miss_latency", lat, 6);
    check_v("cold_miss_arb_addr", 256'(arb_line_q), 256'(27'h000_4000));
    check_i("arb_opcode", int'(arb_op_q), 0);
    read(32'h0000_1010, 3, lat, reqs);
    check_i("rehit_reqs", reqs, 0);
    check_i("rehit_latency", lat, 1);
    read(32'h0000_1020, 3, lat, reqs);
    check_i("second_line_reqs", reqs, 1);

    // Streaming hits across two cached lines
    saddr = '{32'h1000, 32'h1010, 32'h1020, 32'h1030, 32'h1030, 32'h1000, 32'h1010, 32'h1020};
    p0 = pkt_cyc.size();
    r0 = arb_reqs;
    rlow = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      il1c_re   = 1'b1;
      il1c_addr = saddr[i][31:4];
      @(negedge clk);
      if (il1c_ready) exp_q.push_back(exp_pkt(saddr[i]));
      else rlow++;
    end
    @(posedge clk); #1;
    il1c_re = 1'b0;
    drain();
    check_i("stream_ready_low", rlow, 0);
    check_i("stream_pkt_count", pkt_cyc.size() - p0, 8);
    check_i("stream_span", (pkt_cyc.size() >= p0 + 8) ? pkt_cyc[$] - pkt_cyc[p0] : -1, 7);
    check_i("stream_reqs", arb_reqs - r0, 0);

    // Round-robin replacement in set 3
    read(A, 2, lat, reqs); check_i("repl_A1", reqs, 1);
    read(B, 2, lat, reqs); check_i("repl_B1", reqs, 1);
    read(C, 2, lat, reqs); check_i("repl_C1", reqs, 1);
    read(A, 2, lat, reqs); check_i("repl_A2_evicted", reqs, 1);
    read(B, 2, lat, reqs); check_i("repl_B2_evicted", reqs, 1);
    read(A, 2, lat, reqs); check_i("repl_A3_hit", reqs, 0);

    // Arbiter stall for 5 cycles
    arb_lat = 2;
    r0 = arb_reqs;
    il1c2arb_stall = 1'b1;
    issue(32'h0000_5000);
    vcnt = 0;
    n = 0;
    while (vcnt < 5 && n < 50) begin
      @(negedge clk);
      n++;
      if (il1c2arb_valid) vcnt++;
    end
    @(posedge clk); #1;
    il1c2arb_stall = 1'b0;
    @(negedge clk); if (il1c2arb_valid) vcnt++;
    @(negedge clk); if (il1c2arb_valid) vcnt++;
    drain();
    check_i("stall_arb_valid_cycles", vcnt, 6);
    check_i("stall_reqs", arb_reqs - r0, 1);

    // TLB not ready for 4 cycles on a hit
    r0 = arb_reqs;
    tlb_block = 1'b1;
    issue(32'h0000_1000);
    rlow = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (!il1c_ready) rlow++;
    end
    @(posedge clk); #1;
    tlb_block = 1'b0;
    drain();
    check_i("tlb_stall_ready_low", rlow, 4);
    check_i("tlb_stall_reqs", arb_reqs - r0, 0);
    check_i("tlb_stall_latency", pkt_cyc[$] - acc_cyc, 5);

    // Flush with A cached
    @(posedge clk); #1 il1c_flush = 1'b1;
    @(posedge clk); #1 il1c_flush = 1'b0;
    read(A, 2, lat, reqs); check_i("flush_A_miss", reqs, 1);

    // Flush while B fill is outstanding
    arb_lat = 6;
    r0 = arb_reqs;
    issue(B);
    wait_arb_req(r0);
    @(posedge clk); #1 il1c_flush = 1'b1;
    @(posedge clk); #1 il1c_flush = 1'b0;
    drain();
    check_i("flush_wait_pkt_delivered", int'(exp_q.size()), 0);
    read(B, 2, lat, reqs); check_i("flush_wait_B_miss", reqs, 1);

    // Flush coincident with a hit
    r0 = arb_reqs;
    issue(B);
    il1c_flush = 1'b1;
    @(posedge clk); #1 il1c_flush = 1'b0;
    drain();
    check_i("flush_hit_latency", pkt_cyc[$] - acc_cyc, 1);
    check_i("flush_hit_reqs", arb_reqs - r0, 0);
    read(B, 2, lat, reqs); check_i("flush_hit_B_miss", reqs, 1);

    // Reset during WAIT, stray fill data afterwards
    arb_lat = 10;
    r0 = arb_reqs;
    issue(32'h0000_6000);
    wait_arb_req(r0);
    @(posedge clk); #1 rst = 1'b1;
    exp_q.delete();
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check_i("rst_mid_ready", int'(il1c_ready), 1);
    check_i("rst_mid_arb_valid", int'(il1c2arb_valid), 0);
    p0 = pkt_cyc.size();
    repeat (12) @(negedge clk);
    check_i("rst_stray_no_packet", pkt_cyc.size() - p0, 0);
    read(32'h0000_6000, 2, lat, reqs); check_i("rst_first_read_miss", reqs, 1);
    read(32'h0000_6010, 2, lat, reqs); check_i("rst_second_read_hit", reqs, 0);

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
